// File: rtl/psg_pkg.sv
// Shared types for the YM2149 PSG bus master: bus encodings, FSM states
// and the queued request record.
package psg_pkg;

  typedef enum logic [1:0] {
    PSG_INACTIVE = 2'b00,
    PSG_READ     = 2'b01,
    PSG_WRITE    = 2'b10,
    PSG_LATCH    = 2'b11
  } psg_bus_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP1,
    ST_DATA,
    ST_GAP2
  } psg_state_t;

  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] data;
  } psg_req_t;

endpackage

// File: rtl/psg_req_fifo.sv
// Synchronous request FIFO; not_full/empty are registered from the next count
// so they can drive handshake outputs directly.
module psg_req_fifo
  import psg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     CLK,
  input  logic     RESET,
  input  logic     push,
  input  psg_req_t push_req,
  input  logic     pop,
  output psg_req_t head,
  output logic     not_full,
  output logic     empty,
  output logic     empty_nxt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  psg_req_t      mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  always_comb count_nxt = count + CW'(push) - CW'(pop);

  assign empty_nxt = (count_nxt == '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b1;
      empty    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      not_full <= (count_nxt != CW'(FIFO_DEPTH));
      empty    <= empty_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_req;
  end

endmodule

// File: rtl/psg_bus_master.sv
// YM2149 register-port bus initiator: queued requests become latch/gap/data/gap
// BDIR/BC cycles. Optional address cache: PSG_MASTER_ADDR_CACHE_EN.
//
// state   | meaning
// IDLE    | waiting for a CE tick with a queued request
// ADDR    | latch address, held HOLD ticks
// GAP1    | bus inactive for one tick
// DATA    | write or read, held HOLD ticks; read data sampled on the last tick
// GAP2    | bus inactive for one tick, then IDLE
module psg_bus_master
  import psg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD       = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WRITE,
  input  logic [3:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  input  logic [7:0] DI,
  output logic       BUSY
);

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  psg_req_t   head;
  psg_state_t state;
  psg_bus_t   bus;
  logic       push;
  logic       pop;
  logic       empty;
  logic       empty_nxt;
  logic       hit;
  logic       busy_nxt;
  logic [3:0] cnt;
  logic       cur_write;
  logic [7:0] cur_data;

  assign push = REQ_VALID & REQ_READY;
  assign pop  = (state == ST_IDLE) & CE & ~empty;

  psg_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (push),
    .push_req ('{write: REQ_WRITE, addr: REQ_ADDR, data: REQ_DATA}),
    .pop      (pop),
    .head     (head),
    .not_full (REQ_READY),
    .empty    (empty),
    .empty_nxt(empty_nxt)
  );

`ifdef PSG_MASTER_ADDR_CACHE_EN
  logic [3:0] cache_addr;
  logic       cache_vld;
  assign hit = cache_vld & (cache_addr == head.addr);
`else
  assign hit = 1'b0;
`endif

  // BUSY must already be low on the edge that returns to IDLE with nothing queued.
  assign busy_nxt = ~empty_nxt | pop |
                    ((state != ST_IDLE) & ~((state == ST_GAP2) & CE));

  assign {BDIR, BC} = bus;

  always_ff @(posedge CLK) begin
    RSP_VALID <= 1'b0;
    if (RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur_write <= 1'b0;
      cur_data  <= '0;
      bus       <= PSG_INACTIVE;
      DO        <= '0;
      RSP_DATA  <= '0;
      BUSY      <= 1'b0;
`ifdef PSG_MASTER_ADDR_CACHE_EN
      cache_addr <= '0;
      cache_vld  <= 1'b0;
`endif
    end else begin
      BUSY <= busy_nxt;
      if (CE) begin
        case (state)
          ST_IDLE: begin
            if (!empty) begin
              cur_write <= head.write;
              cur_data  <= head.data;
              cnt       <= HOLD_M1;
              if (hit) begin
                state <= ST_DATA;
                bus   <= head.write ? PSG_WRITE : PSG_READ;
                DO    <= head.write ? head.data : 8'h00;
              end else begin
                state <= ST_ADDR;
                bus   <= PSG_LATCH;
                DO    <= {4'h0, head.addr};
`ifdef PSG_MASTER_ADDR_CACHE_EN
                cache_addr <= head.addr;
                cache_vld  <= 1'b1;
`endif
              end
            end
          end
          ST_ADDR: begin
            if (cnt == '0) begin
              state <= ST_GAP1;
              bus   <= PSG_INACTIVE;
              DO    <= 8'h00;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_GAP1: begin
            state <= ST_DATA;
            cnt   <= HOLD_M1;
            bus   <= cur_write ? PSG_WRITE : PSG_READ;
            DO    <= cur_write ? cur_data : 8'h00;
          end
          ST_DATA: begin
            if (cnt == '0) begin
              state <= ST_GAP2;
              bus   <= PSG_INACTIVE;
              DO    <= 8'h00;
              if (!cur_write) begin
                RSP_VALID <= 1'b1;
                RSP_DATA  <= DI;
              end
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_GAP2: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psg_bus_master.sv
// Bench for psg_bus_master: tick-list reference model checked every cycle,
// plus directed scenarios with hand-computed bus traces.
module tb_psg_bus_master;

  localparam int H     = 2;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CE;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_WRITE;
  logic [3:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       BDIR;
  logic       BC;
  logic [7:0] DO;
  logic [7:0] DI;
  logic       BUSY;

  psg_bus_master #(
    .FIFO_DEPTH(DEPTH),
    .HOLD      (H)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CE       (CE),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR (REQ_ADDR),
    .REQ_DATA (REQ_DATA),
    .RSP_VALID(RSP_VALID),
    .RSP_DATA (RSP_DATA),
    .BDIR     (BDIR),
    .BC       (BC),
    .DO       (DO),
    .DI       (DI),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] bus;
    logic [7:0] dout;
    bit         rsp;
  } tick_t;

  typedef struct {
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
  } mreq_t;

  tick_t      ticks[$];
  mreq_t      mq[$];
  logic [1:0] e_bus;
  logic [7:0] e_do;
  logic [7:0] e_rdata;
  logic       e_rsp;
  logic       e_busy;
  logic       e_ready = 1'b1;
  bit         m_cvld;
  logic [3:0] m_caddr;

  task automatic add_ticks(input int n, input logic [1:0] b, input logic [7:0] d, input bit r);
    tick_t t;
    t.bus = b; t.dout = d; t.rsp = r;
    for (int i = 0; i < n; i++) ticks.push_back(t);
  endtask

  task automatic model_step();
    tick_t t;
    mreq_t r;
    bit    acc;
    bit    hit;
    acc   = REQ_VALID && e_ready;
    e_rsp = 1'b0;
    if (RESET) begin
      mq.delete();
      ticks.delete();
      e_bus = 2'b00; e_do = 8'h00; e_rdata = 8'h00;
      e_busy = 1'b0; e_ready = 1'b1; m_cvld = 1'b0;
      return;
    end
    if (CE) begin
      if (ticks.size() == 0 && mq.size() != 0) begin
        r   = mq.pop_front();
        hit = 1'b0;
`ifdef PSG_MASTER_ADDR_CACHE_EN
        hit = m_cvld && (m_caddr == r.a);
        m_cvld  = 1'b1;
        m_caddr = r.a;
`endif
        if (!hit) begin
          add_ticks(H, 2'b11, {4'h0, r.a}, 1'b0);
          add_ticks(1, 2'b00, 8'h00, 1'b0);
        end
        add_ticks(H, r.w ? 2'b10 : 2'b01, r.w ? r.d : 8'h00, 1'b0);
        add_ticks(1, 2'b00, 8'h00, !r.w);
        add_ticks(1, 2'b00, 8'h00, 1'b0);
      end
      if (ticks.size() != 0) begin
        t     = ticks.pop_front();
        e_bus = t.bus;
        e_do  = t.dout;
        if (t.rsp) begin
          e_rsp   = 1'b1;
          e_rdata = DI;
        end
      end
    end
    if (acc) begin
      r.w = REQ_WRITE; r.a = REQ_ADDR; r.d = REQ_DATA;
      mq.push_back(r);
    end
    e_ready = (mq.size() < DEPTH);
    e_busy  = (mq.size() != 0) || (ticks.size() != 0);
  endtask

  always @(posedge CLK) model_step();

  always @(negedge CLK) begin
    chk("bus", {BDIR, BC}, e_bus);
    chk("DO", DO, e_do);
    chk("RSP_VALID", RSP_VALID, e_rsp);
    if (e_rsp) chk("RSP_DATA", RSP_DATA, e_rdata);
    chk("BUSY", BUSY, e_busy);
    chk("REQ_READY", REQ_READY, e_ready);
  end

  // ---------------- trace recorder ----------------
  int         k;
  int         n_busy, n_latch, n_latch_rise, n_wr, n_rsp, rsp_idx;
  logic [7:0] rsp_last;
  logic [1:0] prev_bus = 2'b00;
  logic [1:0] tr_bus [16];
  logic [7:0] tr_do  [16];
  logic [7:0] wq[$];

  always @(negedge CLK) begin
    if (k < 16) begin
      tr_bus[k] = {BDIR, BC};
      tr_do[k]  = DO;
    end
    if (BUSY) n_busy++;
    if ({BDIR, BC} == 2'b11) begin
      n_latch++;
      if (prev_bus != 2'b11) n_latch_rise++;
    end
    if ({BDIR, BC} == 2'b10) begin
      n_wr++;
      if (prev_bus != 2'b10) wq.push_back(DO);
    end
    if (RSP_VALID) begin
      n_rsp++;
      rsp_last = RSP_DATA;
      rsp_idx  = k;
    end
    prev_bus = {BDIR, BC};
    k++;
  end

  task automatic rec_clear();
    k = 0; n_busy = 0; n_latch = 0; n_latch_rise = 0; n_wr = 0; n_rsp = 0;
    rsp_idx = -1; rsp_last = 8'h00;
    wq.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic push_req(input logic w, input logic [3:0] a, input logic [7:0] d);
    bit done = 1'b0;
    bit rdy;
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_DATA = d;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge CLK);
      rdy = REQ_READY;
      @(posedge CLK);
      #1;
      done = rdy;
    end
    REQ_VALID = 1'b0;
    if (done) n_acc++;
    else begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: addr %0h not accepted within 300 cycles", a);
    end
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 500; i++) begin
      @(posedge CLK);
      #1;
      if (!BUSY) break;
    end
    if (BUSY) begin
      n_vec++; n_err++;
      $display("FAIL %s_idle_timeout: BUSY still 1 after 500 cycles", nm);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  logic [1:0] exp_bus1 [8] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
  logic [7:0] exp_do1  [8] = '{8'h00, 8'h07, 8'h07, 8'h00, 8'h38, 8'h38, 8'h00, 8'h00};
  logic       t3_w [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] t3_d [6] = '{8'h11, 8'h00, 8'h33, 8'h00, 8'h55, 8'h66};
  logic [7:0] t3_wexp [4] = '{8'h11, 8'h33, 8'h55, 8'h66};

  initial begin
    int exp_lat;
    RESET = 1'b1; CE = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0;
    REQ_ADDR = 4'h0; REQ_DATA = 8'h00; DI = 8'h00;
    rec_clear();
    cycles(3);

    // reset values
    chk("rst_bus", {BDIR, BC}, 2'b00);
    chk("rst_DO", DO, 8'h00);
    chk("rst_RSP_VALID", RSP_VALID, 1'b0);
    chk("rst_RSP_DATA", RSP_DATA, 8'h00);
    chk("rst_BUSY", BUSY, 1'b0);
    chk("rst_REQ_READY", REQ_READY, 1'b1);
    RESET = 1'b0;
    cycles(2);

    // write reg 7 = 0x38
    push_req(1'b1, 4'd7, 8'h38);
    rec_clear();
    wait_idle("t1");
    cycles(2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_bus[%0d]", i), tr_bus[i], exp_bus1[i]);
      chk($sformatf("t1_do[%0d]", i), tr_do[i], exp_do1[i]);
    end
    chk("t1_busy_cycles", n_busy, 7);

    // read reg 8, PSG returns 0x0F
    DI = 8'h0F;
    push_req(1'b0, 4'd8, 8'hEE);
    rec_clear();
    wait_idle("t2");
    cycles(2);
    chk("t2_latch_cycles", n_latch, 2);
    chk("t2_rsp_count", n_rsp, 1);
    chk("t2_rsp_data", rsp_last, 8'h0F);
    chk("t2_rsp_idx", rsp_idx, 6);

    // six requests while CE stalls the bus
    CE = 1'b0;
    n_acc = 0;
    rec_clear();
    fork
      begin
        for (int i = 0; i < 6; i++) push_req(t3_w[i], 4'(i + 1), t3_d[i]);
      end
      begin
        cycles(12);
        chk("t3_accepts_while_stalled", n_acc, 4);
        chk("t3_ready_full", REQ_READY, 1'b0);
        CE = 1'b1;
        for (int i = 0; i < 400 && (n_acc < 6 || BUSY); i++) begin
          DI = DI + 8'h11;
          cycles(1);
        end
      end
    join
    wait_idle("t3");
    cycles(2);
    chk("t3_latch_phases", n_latch_rise, 6);
    chk("t3_rsp_count", n_rsp, 2);
    chk("t3_write_count", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++)
      chk($sformatf("t3_write_order[%0d]", i), wq[i], t3_wexp[i]);

    // two writes to reg 0
    rec_clear();
    push_req(1'b1, 4'd0, 8'h12);
    push_req(1'b1, 4'd0, 8'h34);
    wait_idle("t4");
    cycles(2);
`ifdef PSG_MASTER_ADDR_CACHE_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    chk("t4_latch_phases", n_latch_rise, exp_lat);
    chk("t4_write_count", wq.size(), 2);
    if (wq.size() == 2) chk("t4_second_write_DO", wq[1], 8'h34);

    // CE 1-in-3
    rec_clear();
    fork
      push_req(1'b1, 4'd5, 8'hA5);
      begin
        for (int i = 0; i < 60; i++) begin
          CE = (i % 3 == 0);
          cycles(1);
        end
      end
    join
    CE = 1'b1;
    wait_idle("t5");
    cycles(2);
    chk("t5_latch_cycles", n_latch, 6);
    chk("t5_write_cycles", n_wr, 6);
    chk("t5_write_count", wq.size(), 1);
    if (wq.size() == 1) chk("t5_write_DO", wq[0], 8'hA5);

    // reset during the data phase of a read
    DI = 8'h5A;
    push_req(1'b0, 4'd3, 8'h00);
    push_req(1'b1, 4'd9, 8'h99);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        cycles(1);
        seen = ({BDIR, BC} == 2'b01);
      end
      chk("t6_read_phase_reached", seen, 1'b1);
    end
    RESET = 1'b1;
    cycles(1);
    RESET = 1'b0;
    chk("t6_bus_after_reset", {BDIR, BC}, 2'b00);
    chk("t6_rsp_after_reset", RSP_VALID, 1'b0);
    chk("t6_busy_after_reset", BUSY, 1'b0);
    chk("t6_ready_after_reset", REQ_READY, 1'b1);
    rec_clear();
    cycles(10);
    chk("t6_no_rsp", n_rsp, 0);
    chk("t6_no_latch", n_latch_rise, 0);
    push_req(1'b1, 4'd3, 8'h77);
    wait_idle("t6");
    cycles(2);
    chk("t6_full_latch", n_latch_rise, 1);
    chk("t6_write_count", wq.size(), 1);
    if (wq.size() == 1) chk("t6_write_DO", wq[0], 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/psg_bus_master.md
# psg_bus_master

Bus initiator for the YM2149 PSG register port. It accepts register write and read requests through a valid/ready handshake and buffers them in a small FIFO. Each request becomes a correctly sequenced BDIR/BC bus cycle: latch address, then write value or read value. The block sits between the CPU-side I/O decode (PPI port logic) or a register-stream player and the PSG instance; read results are returned as a one-cycle response pulse.

## Interface
Parameters:
- FIFO_DEPTH, 4: request FIFO entries; power of two, minimum 2.
- HOLD, 2: number of CE ticks for which each active bus phase (latch, write, read) is held; valid range 1–15.

Ports:
- CLK  in  1  single system clock.
- RESET  in  1  synchronous, active-high reset.
- CE  in  1  bus-phase step enable; all phase counting advances only on CLK edges where CE=1.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  FIFO not full; a transfer occurs when REQ_VALID & REQ_READY.
- REQ_WRITE  in  1  1 = register write, 0 = register read.
- REQ_ADDR  in  4  PSG register number 0–15.
- REQ_DATA  in  8  write value; ignored for reads.
- RSP_VALID  out  1  one-cycle pulse carrying read data; no backpressure.
- RSP_DATA  out  8  read value, valid only while RSP_VALID=1.
- BDIR  out  1  to PSG BDIR.
- BC  out  1  to PSG BC.
- DO  out  8  to PSG DI.
- DI  in  8  from PSG DO.
- BUSY  out  1  high while the FIFO is non-empty or a bus cycle is in progress.

## Operation
- Bus encodings: inactive = BDIR 0, BC 0; read = 0/1; write = 1/0; latch address = 1/1.
- State machine: IDLE, ADDR, GAP1, DATA, GAP2.
- IDLE:
  - If the FIFO is non-empty, pop the head and capture write/addr/data.
  - Go to ADDR. With the cache feature enabled and the address hit, go straight to DATA instead (see Configuration).
- ADDR: bus = latch; DO = {4'h0, addr}; held for HOLD CE ticks, then GAP1.
- GAP1: bus inactive for one CE tick, then DATA.
- DATA, write: bus = write; DO = data; held for HOLD CE ticks.
- DATA, read: bus = read; DO = 8'h00.
  - DI is sampled on the CLK edge of the final CE tick of the phase.
  - RSP_VALID pulses on the following cycle with RSP_DATA = the sampled value.
- GAP2: bus inactive for one CE tick, then IDLE.
- Requests are executed strictly in order; reads and writes may be freely interleaved.
- FIFO full: REQ_READY=0. A request offered while the FIFO is full is not accepted and must be held by the source.
- Simultaneous push and pop when the FIFO is full is permitted; REQ_READY reflects the registered count, i.e. full blocks the push that cycle.

## Timing
- All outputs are registered.
- Reset values: BDIR=0, BC=0, DO=8'h00, RSP_VALID=0, RSP_DATA=8'h00, BUSY=0, REQ_READY=1. State goes to IDLE, the FIFO is emptied and the phase counter is cleared.
- A push lands in the FIFO on the accept edge. IDLE may pop it on the next cycle in which CE=1.
- With CE=1 continuously and HOLD=H:
  - Full write cycle = 1 (pop) + H + 1 + H + 1 = 2H+3 clocks.
  - Read: RSP_VALID asserts 2H+2 clocks after the pop edge.
- Back-to-back requests: IDLE lasts exactly one CE tick between consecutive cycles.
- RESET asserted mid-cycle: on the next edge the bus goes inactive, no RSP_VALID is generated for the aborted read, and pending requests are discarded.
- CE=0 freezes the state, phase counter and bus outputs. FIFO pushes continue to be accepted.

## Configuration
- PSG_MASTER_ADDR_CACHE_EN defined:
  - The block keeps the last latched register number plus a valid bit; the valid bit is cleared on RESET.
  - If a popped request's address equals the cached address and the valid bit is set, ADDR and GAP1 are skipped.
  - Cost of a cache hit: write = H+2 clocks; read response after H+1 clocks.
- PSG_MASTER_ADDR_CACHE_EN undefined: every request performs the full latch sequence, and no cache register exists.

## Structure
- Shared package psg_pkg holds:
  - typedef psg_bus_t, a 2-bit {BDIR,BC} enum (PSG_INACTIVE, PSG_READ, PSG_WRITE, PSG_LATCH);
  - the state enum;
  - the request struct {write, addr[3:0], data[7:0]}.
- Sub-module psg_req_fifo: synchronous FIFO of request structs, parameterised by FIFO_DEPTH, with full/empty flags and synchronous reset.
- The top level contains the FSM, phase counter, optional cache and output registers.

## Test plan
- Reset, then CE=1 and HOLD=1, push write reg 7 = 8'h38 → bus sequence 11, 00, 10, 00 with DO = 8'h07 during latch and 8'h38 during write; BUSY falls after 5 clocks.
- HOLD=2, push read reg 8 with PSG model returning 8'h0F → latch held 2 ticks, read held 2 ticks, a single RSP_VALID with RSP_DATA = 8'h0F.
- Push 6 requests with FIFO_DEPTH=4 while the bus is stalled by CE=0 → REQ_READY drops after 4 accepts; all 6 execute in order once CE returns.
- Cache enabled, two writes to reg 0 (8'h12 then 8'h34) → second write produces no latch phase; DO=8'h34 on the write phase.
- CE toggling 1-in-3 → phase lengths scale ×3 and the bus pattern is otherwise identical to the CE=1 case.
- RESET asserted during the DATA phase of a read → next cycle bus=00, no RSP_VALID, FIFO empty; a subsequent request executes normally with a full latch.
